// File: rtl/gamepad_port.sv
// Bus-mapped poller for an NES-style serial game controller.
// Shifts eight active-low button bits in and exposes them as registers.
module gamepad_port #(
    parameter logic [7:0] DIV_RESET   = 8'd3,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] addr,
    input  logic       cs,
    input  logic       rw,
    input  logic [7:0] di,
    output logic [7:0] dout,
    input  logic       vsync,
    output logic       pad_latch,
    output logic       pad_clk,
    input  logic       pad_data
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SAMPLE,
        CLKHI,
        DONE
    } state_t;

    state_t                 state;
    logic [7:0]             div;
    logic [7:0]             cnt;
    logic [7:0]             buttons;
    logic [7:0]             shreg;
    logic [2:0]             idx;
    logic                   latch_half;
    logic                   new_data;
    logic                   overrun;
    logic                   pending;
    logic                   autopoll;
    logic                   vsync_q;
    logic [SYNC_STAGES-1:0] sync;

    logic pad_sync;
    logic wr;
    logic rd;
    logic busy;
    logic tick;
    logic start_req;
    logic vsync_req;
    logic poll_req;
    logic buttons_rd;
    logic ovr_clr;
    logic done_now;

    assign pad_sync   = sync[SYNC_STAGES-1];
    assign wr         = cs & rw;
    assign rd         = cs & ~rw;
    assign busy       = (state != IDLE);
    assign tick       = (cnt == div);
    assign start_req  = wr && (addr == 4'h2) && di[1];
    assign vsync_req  = autopoll && vsync && !vsync_q;
    assign poll_req   = start_req | vsync_req;
    assign buttons_rd = rd && (addr == 4'h1);
    assign ovr_clr    = wr && (addr == 4'h0) && di[2];
    assign done_now   = (state == DONE);

    // Idle-high so a missing controller reads as "nothing pressed".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pad_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q  <= 1'b0;
            autopoll <= 1'b0;
            div      <= DIV_RESET;
        end else begin
            vsync_q <= vsync;
            if (wr && addr == 4'h2) begin
                autopoll <= di[0];
            end
            if (wr && addr == 4'h3 && !busy) begin
                div <= di;
            end
        end
    end

    // Set events from DONE take priority over bus-side clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buttons  <= 8'h00;
            new_data <= 1'b0;
            overrun  <= 1'b0;
            pending  <= 1'b0;
        end else begin
            if (done_now) begin
                buttons  <= shreg;
                new_data <= 1'b1;
            end else if (buttons_rd) begin
                new_data <= 1'b0;
            end

            if (done_now && new_data) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end

            if (busy && poll_req) begin
                pending <= 1'b1;
            end else if (!busy) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 8'h00;
            latch_half <= 1'b0;
            idx        <= 3'd0;
            shreg      <= 8'h00;
            pad_latch  <= 1'b0;
            pad_clk    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b0;
                    if (poll_req || pending) begin
                        state      <= LATCH;
                        cnt        <= 8'h00;
                        latch_half <= 1'b0;
                        pad_latch  <= 1'b1;
                    end
                end
                LATCH: begin
                    if (tick) begin
                        cnt <= 8'h00;
                        if (latch_half) begin
                            state     <= SAMPLE;
                            idx       <= 3'd0;
                            pad_latch <= 1'b0;
                        end else begin
                            latch_half <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    if (tick) begin
                        cnt        <= 8'h00;
                        shreg[idx] <= ~pad_sync;
                        if (idx == 3'd7) begin
                            state <= DONE;
                        end else begin
                            state   <= CLKHI;
                            pad_clk <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                CLKHI: begin
                    if (tick) begin
                        cnt     <= 8'h00;
                        idx     <= idx + 3'd1;
                        state   <= SAMPLE;
                        pad_clk <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= 8'h00;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= 8'h00;
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        dout = 8'h00;
        if (rd) begin
            case (addr)
                4'h0:    dout = {4'b0000, pending, overrun, new_data, busy};
                4'h1:    dout = buttons;
                4'h2:    dout = {7'b0000000, autopoll};
                4'h3:    dout = div;
                default: dout = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_gamepad_port.sv
// Directed bench for gamepad_port: a small controller model shifts a
// known button pattern while each task checks timing and register values.
module tb_gamepad_port;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] addr = 4'h0;
    logic       cs = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] di = 8'h00;
    logic [7:0] dout;
    logic       vsync = 1'b0;
    logic       pad_latch;
    logic       pad_clk;
    logic       pad_data;

    logic [7:0] pattern = 8'b0111_1110;
    int         bitn = 0;

    int total = 0;
    int bad = 0;

    gamepad_port #(.DIV_RESET(8'd3), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .reset(reset),
        .addr(addr),
        .cs(cs),
        .rw(rw),
        .di(di),
        .dout(dout),
        .vsync(vsync),
        .pad_latch(pad_latch),
        .pad_clk(pad_clk),
        .pad_data(pad_data)
    );

    always #5 clk = ~clk;

    // Controller: latch reloads bit 0, each pad_clk rise advances one bit.
    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) bitn <= 0;
        else           bitn <= bitn + 1;
    end

    always_comb pad_data = (bitn < 8) ? pattern[bitn[2:0]] : 1'b1;

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; addr = a; di = d;
        @(negedge clk);
        cs = 1'b0; rw = 1'b0; di = 8'h00;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; addr = a;
        #1 d = dout;
        @(negedge clk);
        cs = 1'b0;
    endtask

    // Leaves cs asserted on STATUS so the caller can check it right after idle.
    task automatic trig_measure(input bit use_vsync, input logic [7:0] ctrl_val,
                                output int bc, output int lc, output int hc, output int pc);
        bit prev;
        bc = 0; lc = 0; hc = 0; pc = 0; prev = 1'b0;
        @(negedge clk);
        if (use_vsync) vsync = 1'b1;
        else begin
            cs = 1'b1; rw = 1'b1; addr = 4'h2; di = ctrl_val;
        end
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; addr = 4'h0; di = 8'h00;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (!dout[0]) break;
            bc++;
            if (pad_latch) lc++;
            if (pad_clk) begin
                hc++;
                if (!prev) pc++;
            end
            prev = pad_clk;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [7:0] d;
        #23 reset = 1'b0;
        total++; if (pad_latch !== 1'b0) begin bad++; $display("FAIL rst_pad_latch got=%b exp=0", pad_latch); end
        total++; if (pad_clk !== 1'b0) begin bad++; $display("FAIL rst_pad_clk got=%b exp=0", pad_clk); end
        bus_read(4'h0, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_status got=%h exp=00", d); end
        bus_read(4'h1, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_buttons got=%h exp=00", d); end
        bus_read(4'h2, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_ctrl got=%h exp=00", d); end
        bus_read(4'h3, d);
        total++; if (d !== 8'h03) begin bad++; $display("FAIL rst_div got=%h exp=03", d); end
        bus_read(4'h9, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_unmapped got=%h exp=00", d); end
    endtask

    task automatic test_poll;
        int bc, lc, hc, pc;
        logic [7:0] d;
        pattern = 8'b0111_1110;
        trig_measure(1'b0, 8'h02, bc, lc, hc, pc);
        total++; if (bc !== 69) begin bad++; $display("FAIL poll_busy got=%0d exp=69", bc); end
        total++; if (lc !== 8) begin bad++; $display("FAIL poll_latch got=%0d exp=8", lc); end
        total++; if (hc !== 28) begin bad++; $display("FAIL poll_clkhi got=%0d exp=28", hc); end
        total++; if (pc !== 7) begin bad++; $display("FAIL poll_pulses got=%0d exp=7", pc); end
        total++; if (dout !== 8'h02) begin bad++; $display("FAIL poll_status got=%h exp=02", dout); end
        cs = 1'b0;
        bus_read(4'h1, d);
        total++; if (d !== 8'h81) begin bad++; $display("FAIL poll_buttons got=%h exp=81", d); end
        bus_read(4'h0, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL poll_status_cleared got=%h exp=00", d); end
    endtask

    task automatic test_autopoll_div0;
        int bc, lc, hc, pc;
        logic [7:0] d;
        pattern = 8'h00;
        bus_write(4'h2, 8'h01);
        bus_write(4'h3, 8'h00);
        trig_measure(1'b1, 8'h00, bc, lc, hc, pc);
        cs = 1'b0;
        total++; if (bc !== 18) begin bad++; $display("FAIL div0_busy1 got=%0d exp=18", bc); end
        total++; if (lc !== 2) begin bad++; $display("FAIL div0_latch got=%0d exp=2", lc); end
        total++; if (pc !== 7) begin bad++; $display("FAIL div0_pulses got=%0d exp=7", pc); end
        @(negedge clk) vsync = 1'b0;
        repeat (3) @(negedge clk);
        trig_measure(1'b1, 8'h00, bc, lc, hc, pc);
        total++; if (bc !== 18) begin bad++; $display("FAIL div0_busy2 got=%0d exp=18", bc); end
        total++; if (dout !== 8'h06) begin bad++; $display("FAIL div0_overrun got=%h exp=06", dout); end
        cs = 1'b0;
        bus_write(4'h0, 8'h04);
        bus_read(4'h0, d);
        total++; if (d !== 8'h02) begin bad++; $display("FAIL ovr_clear got=%h exp=02", d); end
        bus_read(4'h2, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL ctrl_autopoll got=%h exp=01", d); end
        bus_read(4'h1, d);
        total++; if (d !== 8'hFF) begin bad++; $display("FAIL div0_buttons got=%h exp=ff", d); end
        @(negedge clk) vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_pending;
        int n, bc, extra;
        bus_write(4'h3, 8'h03);
        bus_write(4'h2, 8'h03);
        repeat (3) bus_write(4'h2, 8'h03);
        @(negedge clk) vsync = 1'b1;
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; addr = 4'h0;
        #1;
        total++; if (dout !== 8'h09) begin bad++; $display("FAIL pend_set got=%h exp=09", dout); end
        n = 0;
        while (dout[0] && n < 200) begin
            @(negedge clk); #1; n++;
        end
        total++; if (dout !== 8'h0A) begin bad++; $display("FAIL pend_idle got=%h exp=0a", dout); end
        @(negedge clk); #1;
        total++; if (dout !== 8'h03) begin bad++; $display("FAIL pend_restart got=%h exp=03", dout); end
        bc = 0;
        for (int i = 0; i < 200; i++) begin
            if (!dout[0]) break;
            bc++;
            @(negedge clk); #1;
        end
        total++; if (bc !== 69) begin bad++; $display("FAIL pend_busy got=%0d exp=69", bc); end
        extra = 0;
        repeat (100) begin
            @(negedge clk); #1;
            if (dout[0]) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL pend_single got=%0d exp=0", extra); end
        cs = 1'b0;
    endtask

    task automatic test_div_busy;
        int bc;
        logic [7:0] d;
        bus_write(4'h2, 8'h02);
        bus_write(4'h3, 8'h10);
        cs = 1'b1; rw = 1'b0; addr = 4'h0;
        #1;
        bc = 0;
        for (int i = 0; i < 300; i++) begin
            if (!dout[0]) break;
            bc++;
            @(negedge clk); #1;
        end
        cs = 1'b0;
        total++; if (bc !== 67) begin bad++; $display("FAIL divbusy_timing got=%0d exp=67", bc); end
        bus_read(4'h3, d);
        total++; if (d !== 8'h03) begin bad++; $display("FAIL divbusy_div got=%h exp=03", d); end
        bus_read(4'h0, d);
        total++; if (d !== 8'h06) begin bad++; $display("FAIL divbusy_status got=%h exp=06", d); end
    endtask

    task automatic test_reset_midpoll;
        int act;
        logic [7:0] d;
        bus_write(4'h2, 8'h02);
        repeat (29) @(negedge clk);
        #1;
        total++; if (pad_clk !== 1'b1) begin bad++; $display("FAIL mid_clkhi got=%b exp=1", pad_clk); end
        #1 reset = 1'b1;
        #1;
        total++; if (pad_latch !== 1'b0) begin bad++; $display("FAIL mid_latch got=%b exp=0", pad_latch); end
        total++; if (pad_clk !== 1'b0) begin bad++; $display("FAIL mid_clk got=%b exp=0", pad_clk); end
        cs = 1'b1; rw = 1'b0; addr = 4'h0;
        #1;
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL mid_status got=%h exp=00", dout); end
        addr = 4'h1;
        #1;
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL mid_buttons got=%h exp=00", dout); end
        cs = 1'b0;
        @(negedge clk) reset = 1'b0;
        act = 0;
        repeat (100) begin
            @(negedge clk);
            if (pad_latch || pad_clk) act++;
        end
        total++; if (act !== 0) begin bad++; $display("FAIL mid_quiet got=%0d exp=0", act); end
        bus_read(4'h0, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL mid_status_after got=%h exp=00", d); end
        bus_read(4'h1, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL mid_buttons_after got=%h exp=00", d); end
        bus_read(4'h3, d);
        total++; if (d !== 8'h03) begin bad++; $display("FAIL mid_div_after got=%h exp=03", d); end
    endtask

    initial begin
        test_reset;
        test_poll;
        test_autopoll_div0;
        test_pending;
        test_div_busy;
        test_reset_midpoll;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gamepad_port.md
Name: gamepad_port

Overview:
- Memory-mapped responder on the CPU/control bus. Same bus signals as the text buffer and sprite peripherals: addr, cs, rw (1 = write), di, dout.
- Drives a serial shift-register game controller (NES-style latch/clock/data) and exposes the 8 button states as registers.
- A poll starts on a bus command or automatically on each vsync rising edge.
- The address decoder gives it a 16-byte window; its dout is OR/mux-merged into cpu_di.

Parameters:
- DIV_RESET, 8'd3, reset value of DIV. Serial tick period = DIV+1 clk cycles.
- SYNC_STAGES, 2, number of synchroniser flops on pad_data (minimum 2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  4  register select.
- cs  in  1  chip select.
- rw  in  1  1 = write, 0 = read.
- di  in  8  write data.
- dout  out  8  read data. Combinational from addr when cs & ~rw, otherwise 8'h00.
- vsync  in  1  frame sync level; its rising edge is the auto-poll trigger.
- pad_latch  out  1  controller latch strobe, active high.
- pad_clk  out  1  controller shift clock.
- pad_data  in  1  controller serial data; asynchronous input, active-low button.

Behaviour:
- Register map:
  - 0x0 STATUS. Read: bit0 busy, bit1 new_data, bit2 overrun, bit3 pending, bits[7:4] = 0. Write: 1 to bit2 clears overrun; all other bits ignored.
  - 0x1 BUTTONS, read-only. bit0 = first serial bit (A) through bit7 = eighth bit (Right); 1 = pressed.
  - 0x2 CTRL. bit0 autopoll, read/write. bit1 start: write-only, self-clearing, reads 0. Other bits read 0.
  - 0x3 DIV, read/write. Writes are dropped while busy.
  - 0x4..0xF read 8'h00; writes are ignored.
- Reset values: dout 0 (cs low), pad_latch 0, pad_clk 0, BUTTONS 0, new_data 0, overrun 0, pending 0, autopoll 0, DIV = DIV_RESET, state IDLE, sync flops 1.
- Poll requests:
  - A request is either a write to CTRL with di[1]=1, or a vsync 0->1 edge (registered previous-vsync compare) while autopoll=1.
  - A request in IDLE enters LATCH on the next edge.
  - A request while busy sets pending. Any number of requests collapse into one pending. Pending is consumed when the FSM returns to IDLE, and LATCH is entered on the following edge.
- Tick counter: counts 0..DIV, cleared on every state entry. "Tick" means counter == DIV.
- FSM:
  - IDLE: pad_latch 0, pad_clk 0, busy 0.
  - LATCH: pad_latch 1. Lasts 2 ticks, then SAMPLE with idx = 0.
  - SAMPLE: pad_clk 0. On its tick, shreg[idx] <= ~pad_sync. If idx == 7 go to DONE, else go to CLKHI.
  - CLKHI: pad_clk 1. On its tick, idx <= idx+1 and go to SAMPLE.
  - DONE: lasts 1 cycle. BUTTONS <= shreg. If new_data is already 1, overrun <= 1. new_data <= 1. Then IDLE.
- Poll duration: from LATCH entry to IDLE = 17*(DIV+1)+1 cycles (69 cycles at DIV=3). busy = (state != IDLE).
- BUTTONS read: a clock edge with cs & ~rw & addr==1 clears new_data. If DONE occurs in the same cycle, set wins: new_data stays 1 and BUTTONS shows the new value.
- Overrun: if a STATUS bit2 clear write and a DONE-with-overrun occur in the same cycle, set wins.
- Reads are side-effect free except the BUTTONS new_data clear. dout reflects current register contents in the same cycle.
- DIV = 0 is legal: every cycle is a tick, 18-cycle poll.
- Asynchronous reset mid-poll forces every reset value immediately. pad_latch and pad_clk drop to 0 without completing the sequence.
- shreg is not visible on the bus. A partial poll never updates BUTTONS.

Test Plan:
- Reset, then read all registers -> STATUS 0x00, BUTTONS 0x00, CTRL 0x00, DIV 0x03; pad_latch=pad_clk=0.
- Model drives serial bits 0,1,1,1,1,1,1,0 (active low, first bit first); write CTRL=0x02 -> pad_latch high 8 cycles; 7 pad_clk pulses of 4 cycles high; busy for 69 cycles; then BUTTONS=0x81, STATUS=0x02. Read BUTTONS -> next STATUS=0x00.
- Set CTRL=0x01, DIV=0; give 2 vsync edges without reading BUTTONS -> each poll is 18 cycles; STATUS=0x06 after the second. Write STATUS=0x04 -> STATUS=0x02.
- During a busy poll, write start 3 times and give 1 vsync edge -> pending=1; exactly one extra poll runs, starting 1 cycle after IDLE.
- Write DIV=0x10 while busy -> DIV still reads 0x03; the poll timing is unchanged.
- Assert reset at cycle 30 of a poll -> outputs go low immediately; BUTTONS keeps 0x00; no new_data.
